// File: rtl/vec_inst_issue.sv
// Instruction-side sequencer: fetches slots from a small program buffer, decodes
// the halt word and strip-mines each instruction into lane-group issue beats.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; program buffer writable
// S_FETCH  | inst_q <= buffer[pc]
// S_DECODE | zero word halts the run, otherwise begin issuing at beat 0
// S_ISSUE  | present beat, advance on valid & ready
// S_DONE   | one-cycle completion pulse
module vec_inst_issue #(
  parameter  int NUM_INST = 6,
  parameter  int INST_W   = 32,
  parameter  int VLEN     = 32,
  parameter  int VLANES   = 16,
  localparam int BEATS    = VLEN / VLANES,
  localparam int AW       = $clog2(NUM_INST),
  localparam int PCW      = AW + 1,
  localparam int LGW      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we_i,
  input  logic [AW-1:0]     prog_addr_i,
  input  logic [INST_W-1:0] prog_data_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_out_o,
  output logic [LGW-1:0]    lane_grp_o,
  output logic [PCW-1:0]    pc_o,
  output logic [2:0]        f_d_cycle_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [LGW-1:0] LAST_BEAT = LGW'(BEATS - 1);
  localparam logic [PCW-1:0] LAST_PC   = PCW'(NUM_INST - 1);

  state_t              state_q, state_d;
  logic [PCW-1:0]      pc_q, pc_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [LGW-1:0]      beat_q, beat_d;
  logic [INST_W-1:0]   mem_q [NUM_INST];
  logic                xfer;
  logic                prog_wr;

  assign xfer    = (state_q == S_ISSUE) && inst_ready_i;
  // Out-of-range slot indexes are silently dropped rather than aliased.
  assign prog_wr = (state_q == S_IDLE) && prog_we_i &&
                   ({1'b0, prog_addr_i} < PCW'(NUM_INST));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        inst_d  = mem_q[pc_q[AW-1:0]];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (inst_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
          beat_d  = '0;
        end
      end
      S_ISSUE: begin
        if (xfer) begin
          if (beat_q != LAST_BEAT) begin
            beat_d = beat_q + 1'b1;
          end else if (pc_q == LAST_PC) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_INST; i++) mem_q[i] <= '0;
    end else if (prog_wr) begin
      mem_q[prog_addr_i] <= prog_data_i;
    end
  end

  // All outputs decode from registered state; inst_ready_i reaches none of them.
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign inst_valid_o = (state_q == S_ISSUE);
  assign inst_out_o   = inst_valid_o ? inst_q : '0;
  assign lane_grp_o   = inst_valid_o ? beat_q : '0;
  assign pc_o         = pc_q;
  assign f_d_cycle_o  = state_q;

endmodule

// File: tb/tb_vec_inst_issue.sv
// Self-checking bench for vec_inst_issue: a transaction-level model expands the
// program into the expected beat list and run length, checked every cycle.
module tb_vec_inst_issue;
  localparam int NI    = 6;
  localparam int IW    = 32;
  localparam int VL    = 32;
  localparam int VN    = 16;
  localparam int BEATS = VL / VN;
  localparam int AW    = $clog2(NI);
  localparam int PCW   = AW + 1;
  localparam int LGW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           prog_we = 1'b0;
  logic [AW-1:0]  prog_addr = '0;
  logic [IW-1:0]  prog_data = '0;
  logic           start = 1'b0;
  logic           inst_ready = 1'b0;
  logic           busy, done, inst_valid;
  logic [IW-1:0]  inst_out;
  logic [LGW-1:0] lane_grp;
  logic [PCW-1:0] pc;
  logic [2:0]     fdc;

  vec_inst_issue #(.NUM_INST(NI), .INST_W(IW), .VLEN(VL), .VLANES(VN)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we_i(prog_we), .prog_addr_i(prog_addr),
    .prog_data_i(prog_data), .start_i(start), .busy_o(busy), .done_o(done),
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready), .inst_out_o(inst_out),
    .lane_grp_o(lane_grp), .pc_o(pc), .f_d_cycle_o(fdc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_eq(input string name, input longint act, input longint exp);
    chk(name, act == exp, act, exp);
  endtask

  function automatic bit ph_ok(input int p, input int c);
    case (p)
      0:       return (c == 0) || (c == 1);
      1:       return c == 2;
      2:       return (c == 3) || (c == 4);
      3:       return (c == 3) || (c == 1) || (c == 4);
      4:       return c == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Behavioural model: program image plus expected beat stream of the current run.
  typedef struct {
    logic [IW-1:0] inst;
    int            lg;
    int            slot;
  } beat_t;

  logic [IW-1:0] mdl_mem [NI];
  beat_t q[$];
  bit running = 0;
  bit first_valid_seen;
  int n, stalls, xfers, exp_n_base, exp_pc_final;
  int exp_pc_idle = 0;
  int prev_ph = 0;
  int done_cnt = 0;
  int last_n, last_stalls, last_xfers, last_pc;
  int rd_mode = 0;
  int bp_k = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      running     = 0;
      q.delete();
      prev_ph     = 0;
      exp_pc_idle = 0;
    end else begin
      bit was_running;
      was_running = running;
      chk("phase_trans", ph_ok(prev_ph, int'(fdc)), prev_ph * 10 + int'(fdc), -1);
      prev_ph = int'(fdc);
      if (running) begin
        n++;
        chk_eq("busy_run", busy, 1);
        if (inst_valid) begin
          if (!first_valid_seen) begin
            chk_eq("first_valid_n", n, 3);
            first_valid_seen = 1;
          end
          chk_eq("fdc_issue", fdc, 3);
          if (q.size() == 0) begin
            chk("unexpected_beat", 1'b0, inst_out, 0);
          end else begin
            chk_eq("inst_out", inst_out, q[0].inst);
            chk_eq("lane_grp", lane_grp, q[0].lg);
            chk_eq("pc_issue", pc, q[0].slot);
            if (inst_ready) begin
              void'(q.pop_front());
              xfers++;
            end else begin
              stalls++;
            end
          end
        end
        if (done) begin
          chk_eq("done_n", n, exp_n_base + stalls);
          chk_eq("pc_done", pc, exp_pc_final);
          chk_eq("beats_left", q.size(), 0);
          chk_eq("fdc_done", fdc, 4);
          last_n      = n;
          last_stalls = stalls;
          last_xfers  = xfers;
          last_pc     = int'(pc);
          exp_pc_idle = exp_pc_final;
          done_cnt++;
          running = 0;
        end else begin
          chk("fdc_not_done", fdc != 3'd4, fdc, 0);
          if (n > 4000) begin
            chk("run_cycle_budget", 1'b0, n, 4000);
            running = 0;
          end
        end
      end else begin
        chk_eq("idle_busy", busy, 0);
        chk_eq("idle_done", done, 0);
        chk_eq("idle_valid", inst_valid, 0);
        chk_eq("idle_fdc", fdc, 0);
        chk_eq("idle_pc", pc, exp_pc_idle);
      end
      if (!was_running && start) begin
        q.delete();
        exp_n_base   = 1;
        exp_pc_final = NI - 1;
        for (int s = 0; s < NI; s++) begin
          if (mdl_mem[s] == '0) begin
            exp_pc_final = s;
            exp_n_base += 2;
            break;
          end
          for (int b = 0; b < BEATS; b++) q.push_back('{mdl_mem[s], b, s});
          exp_n_base += 2 + BEATS;
        end
        running = 1;
        first_valid_seen = 0;
        n = 0;
        stalls = 0;
        xfers = 0;
      end
    end
  end

  initial begin
    inst_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        0: inst_ready = 1'b1;
        1: inst_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (inst_valid && lane_grp == 1 && pc == 2 && bp_k < 5) begin
            inst_ready = 1'b0;
            bp_k++;
          end else begin
            inst_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input int a, input logic [IW-1:0] d);
    prog_we   = 1'b1;
    prog_addr = a[AW-1:0];
    prog_data = d;
    tick();
    prog_we   = 1'b0;
    if (a < NI) mdl_mem[a] = d;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) tick();
    chk("run_timeout", done_cnt != d0, done_cnt, d0 + 1);
    tick();
    tick();
  endtask

  task automatic run_prog();
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0);
  endtask

  task automatic chk_zero(input string tag);
    chk_eq({tag, "_busy"}, busy, 0);
    chk_eq({tag, "_done"}, done, 0);
    chk_eq({tag, "_valid"}, inst_valid, 0);
    chk_eq({tag, "_inst"}, inst_out, 0);
    chk_eq({tag, "_lg"}, lane_grp, 0);
    chk_eq({tag, "_pc"}, pc, 0);
    chk_eq({tag, "_fdc"}, fdc, 0);
  endtask

  initial begin
    int d0;
    bit found;
    for (int s = 0; s < NI; s++) mdl_mem[s] = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Full run, continuous ready
    for (int s = 0; s < NI; s++) write_slot(s, 32'h57 + s);
    rd_mode = 0;
    run_prog();
    chk_eq("full_done_n", last_n, 25);
    chk_eq("full_xfers", last_xfers, 12);
    chk_eq("full_pc", last_pc, 5);

    // Program write and second start during a run are ignored
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = inst_valid;
    end
    chk_eq("ign_reach_issue", found, 1);
    prog_we   = 1'b1;
    prog_addr = 3'd4;
    prog_data = 32'hDEADBEEF;
    start     = 1'b1;
    tick();
    prog_we = 1'b0;
    start   = 1'b0;
    wait_done(d0);
    repeat (10) tick();
    chk_eq("ign_one_done", done_cnt - d0, 1);
    chk_eq("ign_xfers", last_xfers, 12);

    // Backpressure on beat 1 of slot 2
    rd_mode = 2;
    run_prog();
    rd_mode = 0;
    chk_eq("bp_stalls", last_stalls, 5);
    chk_eq("bp_xfers", last_xfers, 12);
    chk_eq("bp_done_n", last_n, 30);

    // Halt word in slot 3
    for (int s = 0; s < NI; s++) write_slot(s, (s == 3) ? 32'h0 : ($urandom | 32'h1));
    run_prog();
    chk_eq("halt_done_n", last_n, 15);
    chk_eq("halt_xfers", last_xfers, 6);
    chk_eq("halt_pc", last_pc, 3);

    // Randomised programs, ready and dropped out-of-range writes
    rd_mode = 1;
    for (int r = 0; r < 8; r++) begin
      for (int s = 0; s < NI; s++)
        write_slot(s, ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom | 32'h1));
      write_slot($urandom_range(NI, (1 << AW) - 1), 32'h0);
      run_prog();
    end
    rd_mode = 0;

    // Reset during DECODE of slot 1 loses the run and the program
    for (int s = 0; s < NI; s++) write_slot(s, $urandom | 32'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = (fdc == 3'd2) && (pc == 1);
    end
    chk_eq("rst_reach_decode1", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    for (int s = 0; s < NI; s++) mdl_mem[s] = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    run_prog();
    chk_eq("post_rst_done_n", last_n, 3);
    chk_eq("post_rst_xfers", last_xfers, 0);
    chk_eq("post_rst_pc", last_pc, 0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_inst_issue.md
Name: vec_inst_issue

Overview:
- Instruction-side sequencer for the vector processor: holds a small vector program and drives it into the processor through a fetch/decode/issue cycle.
- Strip-mines each instruction into VLEN/VLANES lane-group beats, each transferred over a valid/ready handshake.
- Exposes the current fetch/decode phase on f_d_cycle.
- Sits between the program loader (bench or host) and the vector datapath's instruction input.

Parameters:
- NUM_INST, 6, program buffer depth (instruction slots).
- INST_W, 32, instruction width in bits.
- VLEN, 32, elements per vector register.
- VLANES, 16, parallel lanes. VLEN/VLANES must be a power of two ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program buffer write strobe.
- prog_addr  in  clog2(NUM_INST)  write slot index; writes to indexes ≥NUM_INST are dropped.
- prog_data  in  INST_W  instruction to store.
- start  in  1  single-cycle run request.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- inst_valid  out  1  issue beat valid.
- inst_ready  in  1  processor accepts the beat.
- inst_out  out  INST_W  instruction being issued.
- lane_grp  out  max(1,clog2(VLEN/VLANES))  beat index; selects element group.
- pc  out  clog2(NUM_INST)+1  current slot index.
- f_d_cycle  out  3  phase code: IDLE=0, FETCH=1, DECODE=2, ISSUE=3, DONE=4.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; every output 0.
  - Program buffer cleared to all-zero; internal instruction register and beat counter cleared.
- Program writes:
  - In IDLE, prog_we writes prog_data to slot prog_addr on the clock edge.
  - prog_we is ignored in all other states.
- IDLE: start=1 at an edge → FETCH, pc=0. start in any other state is ignored.
- FETCH (1 cycle): inst_reg ← buffer[pc] → DECODE.
- DECODE (1 cycle):
  - inst_reg==0 is the halt word → DONE; pc is held.
  - Otherwise → ISSUE with beat=0.
- ISSUE:
  - inst_valid=1, inst_out=inst_reg, lane_grp=beat.
  - A transfer occurs on an edge with inst_valid&inst_ready.
  - Transfer and beat<last: beat++; stay in ISSUE.
  - Transfer and beat==last: if pc==NUM_INST-1 → DONE; else pc++ → FETCH.
  - No transfer: inst_valid, inst_out and lane_grp hold stable. No timeout.
- DONE: done=1, busy=1 for exactly one cycle → IDLE. pc holds its final value until the next start.
- Outputs are registered or decoded from state only; inst_ready has no combinational path to any output.
- Timing per instruction with continuous ready: 2 + VLEN/VLANES cycles.
  - inst_valid is first visible 2 cycles after the start edge.
- Reset asserted mid-run: the run is aborted immediately, and the program is lost.

Test Plan:
- Full run:
  - Stimulus: load slots 0–5 with 0x00000057+i; start at edge k; inst_ready=1.
  - Response: 12 transfers in slot order, lane_grp 0,1 per slot; inst_valid first visible after edge k+2; done visible for the single cycle after edge k+24; busy low after k+25; pc=5.
- Halt word:
  - Stimulus: slot 3 = 0; slots 0–2 nonzero.
  - Response: 6 transfers, no transfer of slot 3; done asserted after DECODE of slot 3; final pc=3.
- Backpressure:
  - Stimulus: inst_ready low for 5 cycles during beat 1 of slot 2.
  - Response: inst_out=slot2 value, lane_grp=1, inst_valid=1 stable throughout; exactly one transfer when ready rises; f_d_cycle=3 throughout.
- Ignored requests:
  - Stimulus: prog_we to slot 4 with 0xDEADBEEF during ISSUE; second start pulse mid-run.
  - Response: slot 4 retains its original value on issue; only one done pulse.
- Mid-run reset:
  - Stimulus: rst_n low for 1 cycle during DECODE of slot 1.
  - Response: all outputs 0 asynchronously; f_d_cycle=0; a following start (no reload) halts at slot 0 with zero transfers and done after 2 cycles.
- Phase trace:
  - Check f_d_cycle follows 0→1→2→3→3→1… through a run.
  - Check it reads 4 only in the done cycle.
